// File: rtl/arith_pkg.sv
// Shared constants and word types for the arith_unit datapath slice.
package arith_pkg;

  localparam int DEFAULT_DATAWIDTH = 16;

  typedef logic [DEFAULT_DATAWIDTH-1:0]   word_t;
  typedef logic [2*DEFAULT_DATAWIDTH-1:0] dword_t;

endpackage

// File: rtl/arith_reg.sv
// DATAWIDTH-wide D register with asynchronous active-low clear; no enable.
module arith_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage stage: clear immediately on reset, otherwise capture d every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/arith_unit.sv
// Unsigned adder, multiplier and register lanes sharing one operand width.
// Optional carry/overflow flag ports are enabled by defining ARITH_FLAGS_EN.
module arith_unit
  import arith_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] add_result,
  output logic [DATAWIDTH-1:0] mul_result,
  output logic [DATAWIDTH-1:0] reg_result
`ifdef ARITH_FLAGS_EN
  ,
  output logic                 add_carry,
  output logic                 mul_ovf
`endif
);

`ifdef ARITH_FLAGS_EN
  logic [DATAWIDTH:0]     sum_s;
  logic [2*DATAWIDTH-1:0] prod_s;

  // Widen both operands so the carry and the upper product half are kept.
  assign sum_s      = {1'b0, a} + {1'b0, b};
  assign prod_s     = {{DATAWIDTH{1'b0}}, a} * {{DATAWIDTH{1'b0}}, b};
  assign add_result = sum_s[DATAWIDTH-1:0];
  assign add_carry  = sum_s[DATAWIDTH];
  assign mul_result = prod_s[DATAWIDTH-1:0];
  assign mul_ovf    = |prod_s[2*DATAWIDTH-1:DATAWIDTH];
`else
  assign add_result = a + b;
  assign mul_result = a * b;
`endif

  arith_reg #(
    .WIDTH (DATAWIDTH)
  ) u_reg (
    .clk   (Clk),
    .rst_n (Rst),
    .d     (d),
    .q     (reg_result)
  );

endmodule

// File: tb/tb_arith_unit.sv
// Directed self-checking bench for arith_unit at DATAWIDTH = 16.
module tb_arith_unit;

  localparam int W = 16;

  logic         Clk;
  logic         Rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] d;
  logic [W-1:0] add_result;
  logic [W-1:0] mul_result;
  logic [W-1:0] reg_result;
`ifdef ARITH_FLAGS_EN
  logic         add_carry;
  logic         mul_ovf;
`endif

  int checks;
  int errors;

  arith_unit #(.DATAWIDTH(W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .a          (a),
    .b          (b),
    .d          (d),
    .add_result (add_result),
    .mul_result (mul_result),
    .reg_result (reg_result)
`ifdef ARITH_FLAGS_EN
    ,
    .add_carry  (add_carry),
    .mul_ovf    (mul_ovf)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_comb(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic [W-1:0] exp_add, input logic [W-1:0] exp_mul);
    a = ta;
    b = tb_;
    #1;
    checks++;
    if (add_result !== exp_add) begin
      errors++;
      $display("FAIL %s add_result got %h expected %h", name, add_result, exp_add);
    end
    checks++;
    if (mul_result !== exp_mul) begin
      errors++;
      $display("FAIL %s mul_result got %h expected %h", name, mul_result, exp_mul);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    d   = 16'd5;
    a   = 16'd0;
    b   = 16'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (reg_result !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold reg_result got %h expected %h", reg_result, 16'd0);
    end
    check_comb("comb_in_reset", 16'd4, 16'd4, 16'd8, 16'd16);
    @(negedge Clk);
    Rst = 1'b1;
    d   = 16'd5;
    @(posedge Clk);
    #1;
    checks++;
    if (reg_result !== 16'd5) begin
      errors++;
      $display("FAIL reset_release reg_result got %h expected %h", reg_result, 16'd5);
    end
  endtask

  task automatic test_basic();
    check_comb("basic_4_4", 16'd4, 16'd4, 16'd8, 16'd16);
    check_comb("basic_1_9", 16'd1, 16'd9, 16'd10, 16'd9);
    check_comb("basic_9_1", 16'd9, 16'd1, 16'd10, 16'd9);
    check_comb("basic_big", 16'd300, 16'd200, 16'd500, 16'hEA60);
  endtask

  task automatic test_add_wrap();
    check_comb("add_wrap", 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF);
`ifdef ARITH_FLAGS_EN
    checks++;
    if (add_carry !== 1'b1) begin
      errors++;
      $display("FAIL add_carry_set got %b expected %b", add_carry, 1'b1);
    end
    check_comb("add_nowrap", 16'hFFFE, 16'h0001, 16'hFFFF, 16'hFFFE);
    checks++;
    if (add_carry !== 1'b0) begin
      errors++;
      $display("FAIL add_carry_clr got %b expected %b", add_carry, 1'b0);
    end
`endif
  endtask

  task automatic test_mul_ovf();
    check_comb("mul_ovf", 16'h0100, 16'h0100, 16'h0200, 16'h0000);
`ifdef ARITH_FLAGS_EN
    checks++;
    if (mul_ovf !== 1'b1) begin
      errors++;
      $display("FAIL mul_ovf_set got %b expected %b", mul_ovf, 1'b1);
    end
`endif
    check_comb("mul_noovf", 16'h00FF, 16'h0101, 16'h0200, 16'hFFFF);
`ifdef ARITH_FLAGS_EN
    checks++;
    if (mul_ovf !== 1'b0) begin
      errors++;
      $display("FAIL mul_ovf_clr got %b expected %b", mul_ovf, 1'b0);
    end
`endif
  endtask

  task automatic test_latency();
    logic [W-1:0] prev;
    prev = 16'd5;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      d = 16'(i);
      #1;
      checks++;
      if (reg_result !== prev) begin
        errors++;
        $display("FAIL latency_pre_%0d reg_result got %h expected %h", i, reg_result, prev);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (reg_result !== 16'(i)) begin
        errors++;
        $display("FAIL latency_post_%0d reg_result got %h expected %h", i, reg_result, 16'(i));
      end
      prev = 16'(i);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    d = 16'd3;
    @(posedge Clk);
    #1;
    checks++;
    if (reg_result !== 16'd3) begin
      errors++;
      $display("FAIL mid_load reg_result got %h expected %h", reg_result, 16'd3);
    end
    #2;
    Rst = 1'b0;
    #1;
    checks++;
    if (reg_result !== 16'd0) begin
      errors++;
      $display("FAIL mid_async_clear reg_result got %h expected %h", reg_result, 16'd0);
    end
    d = 16'd9;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (reg_result !== 16'd0) begin
      errors++;
      $display("FAIL mid_hold reg_result got %h expected %h", reg_result, 16'd0);
    end
    @(negedge Clk);
    Rst = 1'b1;
    d   = 16'd7;
    @(posedge Clk);
    #1;
    checks++;
    if (reg_result !== 16'd7) begin
      errors++;
      $display("FAIL mid_release reg_result got %h expected %h", reg_result, 16'd7);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_add_wrap();
    test_mul_ovf();
    test_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
